pcs_pattern_checker: RTL

PCS_PATTERN_CHECKER -- requirements
Module: pcs_pattern_checker

---
 rtl/pcs_pattern_checker.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pcs_pattern_checker.sv
// PCS pattern generator/checker: drives PRBS31, counter or idle blocks
// into an encoder and checks the decoder output after a fixed latency.
module pcs_pattern_checker #(
  parameter int          LEN_DATA_BLOCK = 64,
  parameter int          LEN_CTRL_BLOCK = 8,
  parameter int          MAX_LATENCY    = 16,
  parameter int          NB_ERR_CNT     = 16,
  parameter int          LOCK_CNT       = 4,
  parameter int          UNLOCK_CNT     = 8,
  parameter logic [30:0] SEED           = 31'h7FFFFFFF
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable,
  input  logic [1:0]                     i_mode,
  input  logic [$clog2(MAX_LATENCY)-1:0] i_latency,
  input  logic                           i_clear,
  input  logic [LEN_DATA_BLOCK-1:0]      i_rx_raw_data,
  input  logic [LEN_CTRL_BLOCK-1:0]      i_rx_raw_ctrl,
  output logic [LEN_DATA_BLOCK-1:0]      o_tx_data,
  output logic [LEN_CTRL_BLOCK-1:0]      o_tx_ctrl,
  output logic                           o_lock,
  output logic [NB_ERR_CNT-1:0]          o_err_count,
  output logic                           o_err_flag
);

  localparam int DW = LEN_DATA_BLOCK;
  localparam int CW = LEN_CTRL_BLOCK;
  localparam int LW = $clog2(MAX_LATENCY);
  localparam int MW = $clog2(LOCK_CNT) + 1;
  localparam int UW = $clog2(UNLOCK_CNT) + 1;

  typedef enum logic [1:0] {IDLE, FILL, HUNT, LOCKED} state_t;

  state_t          state;
  logic [30:0]     lfsr;
  logic [DW-1:0]   cnt;
  logic [DW-1:0]   mem_d [MAX_LATENCY];
  logic [CW-1:0]   mem_c [MAX_LATENCY];
  logic [LW-1:0]   wp;
  logic [LW-1:0]   fill_cnt;
  logic [LW-1:0]   lat_q;
  logic [1:0]      mode_q;
  logic [MW-1:0]   match_cnt;
  logic [UW-1:0]   miss_cnt;

  logic [1:0]      mode_eff;
  logic            restart;
  logic [DW-1:0]   gen_data;
  logic [CW-1:0]   gen_ctrl;
  logic [30:0]     nxt_lfsr;
  logic [DW-1:0]   nxt_cnt;
  logic [LW-1:0]   rd_ptr;
  logic            match;
  logic            err_hit;

  assign mode_eff = (i_mode == 2'd3) ? 2'd0 : i_mode;
  assign restart  = (state == IDLE) || (mode_eff != mode_q)
                 || (i_latency != lat_q);
  assign rd_ptr   = wp - i_latency - LW'(1);
  assign match    = (i_rx_raw_data == mem_d[rd_ptr])
                 && (i_rx_raw_ctrl == mem_c[rd_ptr]);
  assign err_hit  = !restart && (state == LOCKED) && !match;

  always_comb begin
    logic [30:0]   s;
    logic [DW-1:0] c;
    logic          nb;
    s        = restart ? SEED : lfsr;
    c        = restart ? '0 : cnt;
    nb       = 1'b0;
    gen_data = '0;
    gen_ctrl = '0;
    unique case (mode_eff)
      2'd1: begin
        // MSB carries the earliest PRBS bit of the block
        for (int i = 0; i < DW; i++) begin
          nb = s[30] ^ s[27];
          gen_data[DW-1-i] = nb;
          s = {s[29:0], nb};
        end
      end
      2'd2: begin
        gen_data = c;
        c = c + DW'(1);
      end
      default: begin
        for (int b = 0; b < DW / 8; b++)
          gen_data[8*b +: 8] = 8'h07;
        gen_ctrl = '1;
      end
    endcase
    nxt_lfsr = s;
    nxt_cnt  = c;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      lfsr        <= SEED;
      cnt         <= '0;
      wp          <= '0;
      fill_cnt    <= '0;
      lat_q       <= '0;
      mode_q      <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      o_tx_data   <= '0;
      o_tx_ctrl   <= '0;
      o_lock      <= 1'b0;
      o_err_count <= '0;
      o_err_flag  <= 1'b0;
      for (int k = 0; k < MAX_LATENCY; k++) begin
        mem_d[k] <= '0;
        mem_c[k] <= '0;
      end
    end else if (i_enable) begin
      mode_q    <= mode_eff;
      lat_q     <= i_latency;
      lfsr      <= nxt_lfsr;
      cnt       <= nxt_cnt;
      o_tx_data <= gen_data;
      o_tx_ctrl <= gen_ctrl;
      mem_d[wp] <= gen_data;
      mem_c[wp] <= gen_ctrl;
      wp        <= wp + LW'(1);
      if (restart) begin
        state     <= FILL;
        fill_cnt  <= '0;
        match_cnt <= '0;
        miss_cnt  <= '0;
        o_lock    <= 1'b0;
      end else begin
        unique case (state)
          FILL: begin
            if (fill_cnt == i_latency) state <= HUNT;
            else fill_cnt <= fill_cnt + LW'(1);
          end
          HUNT: begin
            if (!match) begin
              match_cnt <= '0;
            end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state     <= LOCKED;
              o_lock    <= 1'b1;
              match_cnt <= '0;
              miss_cnt  <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end
          LOCKED: begin
            if (match) begin
              miss_cnt <= '0;
            end else if (miss_cnt == UW'(UNLOCK_CNT - 1)) begin
              state     <= HUNT;
              o_lock    <= 1'b0;
              miss_cnt  <= '0;
              match_cnt <= '0;
            end else begin
              miss_cnt <= miss_cnt + UW'(1);
            end
          end
          default: state <= FILL;
        endcase
      end
      if (i_clear) begin
        o_err_count <= '0;
        o_err_flag  <= 1'b0;
      end else if (err_hit) begin
        if (o_err_count != '1) o_err_count <= o_err_count + NB_ERR_CNT'(1);
        o_err_flag <= 1'b1;
      end
    end
  end

endmodule
